fpu_result_scoreboard: RTL and testbench

Synthesizable, parametrised result checker placed beside the `fpu` instance in the verification top. It replaces the per-cycle software compare. It does three things:
- Carries each issued operation's golden result through a delay line matched to the FPU pipeline latency.
- Compares that result against `fpu` output with IEEE-aware tolerance rules (NaN, signed zero, ULP).
- Keeps saturating per-opcode pass/fail counters and captures the first failure for post-mortem.

---
 rtl/fpu_result_scoreboard.sv | 154 +++++++++++++++
 tb/tb_fpu_result_scoreboard.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_scoreboard.sv
// fpu_result_scoreboard: carries golden results through a delay line matched
// to the FPU latency, compares them against the FPU output with IEEE-aware
// tolerance (NaN, signed zero, ULP distance), keeps saturating per-opcode
// pass/fail counters and captures the first failing compare.
module fpu_result_scoreboard #(
   parameter int EXP_W   = 8,
   parameter int MAN_W   = 23,
   parameter int LATENCY = 4,
   parameter int NUM_OPS = 8,
   parameter int CNT_W   = 16,
   parameter int TOL_ULP = 0,
   localparam int WIDTH  = 1 + EXP_W + MAN_W,
   localparam int OP_W   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     issue_valid,
   input  logic [OP_W-1:0]          issue_op,
   input  logic [WIDTH-1:0]         issue_golden,
   input  logic [WIDTH-1:0]         dut_out,
   input  logic                     clear,
   output logic                     chk_valid,
   output logic                     chk_pass,
   output logic [NUM_OPS*CNT_W-1:0] pass_cnt,
   output logic [NUM_OPS*CNT_W-1:0] fail_cnt,
   output logic                     any_fail,
   output logic [OP_W-1:0]          ff_op,
   output logic [WIDTH-1:0]         ff_exp,
   output logic [WIDTH-1:0]         ff_got
);

   localparam logic [WIDTH-2:0] TOL = (WIDTH-1)'(TOL_ULP);

   // Delay line: stage 0 takes the issue, the last stage meets dut_out.
   logic [LATENCY-1:0] dl_valid;
   logic [OP_W-1:0]    dl_op   [LATENCY];
   logic [WIDTH-1:0]   dl_gold [LATENCY];

   // Compare-stage view of the oldest in-flight operation.
   logic             cmp_valid;
   logic [OP_W-1:0]  cmp_op;
   logic [WIDTH-1:0] g, d;
   logic [EXP_W-1:0] g_exp, d_exp;
   logic [MAN_W-1:0] g_man, d_man;
   logic             g_nan, d_nan, g_inf, d_inf, g_zero, d_zero;
   logic [WIDTH-2:0] g_mag, d_mag, mag_diff;
   logic             cmp_pass;

   // Per-op counters kept unpacked internally, packed onto the ports.
   logic [CNT_W-1:0] pcnt [NUM_OPS];
   logic [CNT_W-1:0] fcnt [NUM_OPS];

   assign cmp_valid = dl_valid[LATENCY-1];
   assign cmp_op    = dl_op[LATENCY-1];
   assign g         = dl_gold[LATENCY-1];
   assign d         = dut_out;

   assign g_exp  = g[WIDTH-2 -: EXP_W];
   assign d_exp  = d[WIDTH-2 -: EXP_W];
   assign g_man  = g[MAN_W-1:0];
   assign d_man  = d[MAN_W-1:0];
   assign g_nan  = (&g_exp) && (|g_man);
   assign d_nan  = (&d_exp) && (|d_man);
   assign g_inf  = (&g_exp) && !(|g_man);
   assign d_inf  = (&d_exp) && !(|d_man);
   assign g_zero = ~|g[WIDTH-2:0];
   assign d_zero = ~|d[WIDTH-2:0];
   assign g_mag  = g[WIDTH-2:0];
   assign d_mag  = d[WIDTH-2:0];
   assign mag_diff = (g_mag >= d_mag) ? (g_mag - d_mag) : (d_mag - g_mag);

   // Inf only matches Inf bitwise; NaN/zero ignore sign; otherwise ULP distance.
   assign cmp_pass = (g == d)
                   || (g_nan && d_nan)
                   || (g_zero && d_zero)
                   || ((g[WIDTH-1] == d[WIDTH-1]) && !g_nan && !d_nan
                       && !g_inf && !d_inf && (mag_diff <= TOL));

   // Shift the delay line every edge; reset discards in-flight operations.
   always_ff @(posedge clk) begin
      if (reset) begin
         dl_valid <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            dl_op[i]   <= '0;
            dl_gold[i] <= '0;
         end
      end else begin
         dl_valid[0] <= issue_valid;
         dl_op[0]    <= issue_op;
         dl_gold[0]  <= issue_golden;
         for (int i = 1; i < LATENCY; i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_op[i]    <= dl_op[i-1];
            dl_gold[i]  <= dl_gold[i-1];
         end
      end
   end

   // Register the compare result; clear does not suppress the report.
   always_ff @(posedge clk) begin
      if (reset) begin
         chk_valid <= 1'b0;
         chk_pass  <= 1'b0;
      end else begin
         chk_valid <= cmp_valid;
         chk_pass  <= cmp_valid && cmp_pass;
      end
   end

   // Saturating per-op counters; out-of-range opcodes match no slot.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int i = 0; i < NUM_OPS; i++) begin
            pcnt[i] <= '0;
            fcnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_OPS; i++) begin
            if (cmp_valid && (int'(cmp_op) == i)) begin
               if (cmp_pass && (pcnt[i] != '1))
                  pcnt[i] <= pcnt[i] + 1'b1;
               if (!cmp_pass && (fcnt[i] != '1))
                  fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   // Capture only the first failure until clear or reset.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         any_fail <= 1'b0;
         ff_op    <= '0;
         ff_exp   <= '0;
         ff_got   <= '0;
      end else if (cmp_valid && !cmp_pass && !any_fail) begin
         any_fail <= 1'b1;
         ff_op    <= cmp_op;
         ff_exp   <= g;
         ff_got   <= d;
      end
   end

   // Pack counters onto the flat output buses.
   always_comb begin
      pass_cnt = '0;
      fail_cnt = '0;
      for (int i = 0; i < NUM_OPS; i++) begin
         pass_cnt[i*CNT_W +: CNT_W] = pcnt[i];
         fail_cnt[i*CNT_W +: CNT_W] = fcnt[i];
      end
   end

endmodule

// File: tb/tb_fpu_result_scoreboard.sv
// Bench for fpu_result_scoreboard: directed cases followed by random traffic,
// all checked against a queue-based reference model of the checker.
module tb_fpu_result_scoreboard;

   localparam int EW   = 8;
   localparam int MW   = 23;
   localparam int LAT  = 4;
   localparam int NOPS = 6;
   localparam int CW   = 4;
   localparam int TOL  = 1;
   localparam int W    = 1 + EW + MW;
   localparam int OPW  = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              issue_valid = 1'b0;
   logic [OPW-1:0]    issue_op = '0;
   logic [W-1:0]      issue_golden = '0;
   logic [W-1:0]      dut_out = '0;
   logic              clear = 1'b0;
   logic              chk_valid, chk_pass, any_fail;
   logic [NOPS*CW-1:0] pass_cnt, fail_cnt;
   logic [OPW-1:0]    ff_op;
   logic [W-1:0]      ff_exp, ff_got;

   fpu_result_scoreboard #(
      .EXP_W(EW), .MAN_W(MW), .LATENCY(LAT), .NUM_OPS(NOPS),
      .CNT_W(CW), .TOL_ULP(TOL)
   ) dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid),
      .issue_op(issue_op), .issue_golden(issue_golden), .dut_out(dut_out),
      .clear(clear), .chk_valid(chk_valid), .chk_pass(chk_pass),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .any_fail(any_fail),
      .ff_op(ff_op), .ff_exp(ff_exp), .ff_got(ff_got)
   );

   // Clock
   always #5 clk = ~clk;

   // Reference model state
   typedef struct {
      logic           v;
      logic [OPW-1:0] op;
      logic [W-1:0]   g;
   } ent_t;
   ent_t exp_q[$];
   int   m_pass [8];
   int   m_fail [8];
   bit   m_any, m_cv, m_cp;
   logic [OPW-1:0] m_ffop;
   logic [W-1:0]   m_ffexp, m_ffgot;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pass/fail verdict from the IEEE field rules.
   function automatic bit ref_pass(input logic [W-1:0] gv, input logic [W-1:0] dv);
      int unsigned ge, de, gm, dm;
      longint diff;
      ge = gv[30:23]; de = dv[30:23];
      gm = gv[22:0];  dm = dv[22:0];
      if (gv == dv) return 1'b1;
      if (ge == 255 && gm != 0 && de == 255 && dm != 0) return 1'b1;
      if (ge == 0 && gm == 0 && de == 0 && dm == 0) return 1'b1;
      if (gv[31] != dv[31]) return 1'b0;
      if (ge == 255 || de == 255) return 1'b0;
      diff = longint'(gv[30:0]) - longint'(dv[30:0]);
      if (diff < 0) diff = -diff;
      return diff <= TOL;
   endfunction

   task automatic model_zero_stats();
      for (int i = 0; i < 8; i++) begin
         m_pass[i] = 0;
         m_fail[i] = 0;
      end
      m_any = 0; m_ffop = '0; m_ffexp = '0; m_ffgot = '0;
   endtask

   task automatic check_all();
      logic [NOPS*CW-1:0] ep, ef;
      for (int i = 0; i < NOPS; i++) begin
         ep[i*CW +: CW] = m_pass[i][CW-1:0];
         ef[i*CW +: CW] = m_fail[i][CW-1:0];
      end
      check("chk_valid", chk_valid, m_cv);
      if (m_cv) check("chk_pass", chk_pass, m_cp);
      check("pass_cnt", pass_cnt, ep);
      check("fail_cnt", fail_cnt, ef);
      check("any_fail", any_fail, m_any);
      check("ff_op", ff_op, m_ffop);
      check("ff_exp", ff_exp, m_ffexp);
      check("ff_got", ff_got, m_ffgot);
   endtask

   // Driver: apply one edge of stimulus, advance the model, check outputs.
   task automatic step(input bit iv, input logic [OPW-1:0] op, input logic [W-1:0] gv,
                       input logic [W-1:0] dv, input bit clr, input bit rst);
      ent_t f;
      @(negedge clk);
      issue_valid = iv; issue_op = op; issue_golden = gv;
      dut_out = dv; clear = clr; reset = rst;
      if (rst) begin
         exp_q.delete();
         for (int i = 0; i < LAT; i++) exp_q.push_back('{v: 1'b0, op: '0, g: '0});
         model_zero_stats();
         m_cv = 0; m_cp = 0;
      end else begin
         f = exp_q.pop_front();
         exp_q.push_back('{v: iv, op: op, g: gv});
         m_cv = f.v;
         m_cp = f.v && ref_pass(f.g, dv);
         if (clr) model_zero_stats();
         else if (f.v) begin
            if (int'(f.op) < NOPS) begin
               if (m_cp && m_pass[f.op] < CMAX) m_pass[f.op]++;
               if (!m_cp && m_fail[f.op] < CMAX) m_fail[f.op]++;
            end
            if (!m_cp && !m_any) begin
               m_any = 1; m_ffop = f.op; m_ffexp = f.g; m_ffgot = dv;
            end
         end
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      step(1'b0, '0, '0, '0, 1'b0, 1'b0);
   endtask

   // One isolated transaction: issue, wait out the latency, present dut value.
   task automatic txn(input logic [OPW-1:0] op, input logic [W-1:0] gv,
                      input logic [W-1:0] dv, input bit clr);
      step(1'b1, op, gv, '0, 1'b0, 1'b0);
      for (int i = 0; i < LAT - 1; i++) idle();
      step(1'b0, '0, '0, dv, clr, 1'b0);
   endtask

   function automatic logic [W-1:0] rand_nan();
      logic [22:0] m;
      m = 23'($urandom_range(1, 32'h7FFFFF));
      return {1'($urandom_range(0, 1)), 8'hFF, m};
   endfunction

   function automatic logic [W-1:0] rand_gold();
      logic s;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
         0: return $urandom;
         1: return rand_nan();
         2: return {s, 31'd0};
         3: return {s, 8'hFF, 23'd0};
         4: return {s, 8'd0, 23'($urandom_range(0, 3))};
         default: return {s, 8'hFE, 23'($urandom)};
      endcase
   endfunction

   function automatic logic [W-1:0] mutate(input logic [W-1:0] gv);
      case ($urandom_range(0, 6))
         0: return gv;
         1: return gv + 32'd1;
         2: return gv - 32'd1;
         3: return gv + 32'd2;
         4: return gv ^ 32'h8000_0000;
         5: return rand_nan();
         default: return $urandom;
      endcase
   endfunction

   initial begin
      // Reset state
      step(1'b0, '0, '0, '0, 1'b0, 1'b1);
      step(1'b0, '0, '0, '0, 1'b0, 1'b1);
      check("rst_pass_cnt", pass_cnt, 0);
      check("rst_chk_valid", chk_valid, 0);

      // Exact match, first-transaction latency
      txn(3'd0, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
      check("t1_valid", chk_valid, 1);
      check("t1_pass", chk_pass, 1);
      check("t1_pass_cnt0", pass_cnt[CW-1:0], 1);
      check("t1_any_fail", any_fail, 0);

      // NaN and signed-zero rules
      txn(3'd3, 32'h7FC0_0000, 32'hFFC0_0001, 1'b0);
      check("nan_pass", chk_pass, 1);
      txn(3'd1, 32'h0000_0000, 32'h8000_0000, 1'b0);
      check("zero_pass", chk_pass, 1);

      // ULP tolerance boundary and first-fail capture
      txn(3'd4, 32'h4000_0000, 32'h4000_0001, 1'b0);
      check("ulp1_pass", chk_pass, 1);
      txn(3'd4, 32'h4000_0000, 32'h4000_0002, 1'b0);
      check("ulp2_pass", chk_pass, 0);
      check("ulp2_fail_cnt4", fail_cnt[4*CW +: CW], 1);
      check("ulp2_ff_exp", ff_exp, 32'h4000_0000);
      check("ulp2_ff_got", ff_got, 32'h4000_0002);
      check("ulp2_any_fail", any_fail, 1);
      txn(3'd5, 32'h3F80_0000, 32'hBF80_0000, 1'b0);
      check("second_ff_exp", ff_exp, 32'h4000_0000);
      check("second_ff_op", ff_op, 4);

      // Inf only matches bitwise
      txn(3'd2, 32'h7F80_0000, 32'h7F7F_FFFF, 1'b0);
      check("inf_pass", chk_pass, 0);

      // Saturation: back-to-back passes on op 2
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 20 + LAT; i++)
         step(i < 20, 3'd2, 32'h3F80_0000 + 32'(i), exp_q[0].g, 1'b0, 1'b0);
      check("sat_pass_cnt2", pass_cnt[2*CW +: CW], 15);

      // Clear on the same edge as a failing compare
      txn(3'd1, 32'h3F80_0000, 32'h4040_0000, 1'b1);
      check("clr_valid", chk_valid, 1);
      check("clr_pass", chk_pass, 0);
      check("clr_fail_cnt", fail_cnt, 0);
      check("clr_any_fail", any_fail, 0);

      // Out-of-range opcode: not counted, still captured
      txn(3'd6, 32'h3F80_0000, 32'h4040_0000, 1'b0);
      check("oor_fail_cnt", fail_cnt, 0);
      check("oor_any_fail", any_fail, 1);
      check("oor_ff_op", ff_op, 6);

      // Reset mid-stream discards in-flight operations
      step(1'b1, 3'd0, 32'h1, '0, 1'b0, 1'b0);
      step(1'b1, 3'd1, 32'h2, '0, 1'b0, 1'b0);
      step(1'b1, 3'd2, 32'h3, '0, 1'b0, 1'b0);
      idle();
      step(1'b0, '0, '0, '0, 1'b0, 1'b1);
      check("mrst_any_fail", any_fail, 0);
      check("mrst_ff_got", ff_got, 0);
      for (int i = 0; i < LAT + 2; i++) begin
         idle();
         check("mrst_no_valid", chk_valid, 0);
      end

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rand_gold(),
              mutate(exp_q[0].g), $urandom_range(0, 40) == 0,
              $urandom_range(0, 200) == 0);
      end
      for (int i = 0; i < LAT; i++) idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
